// File: rtl/fork_sensor_gen.sv
// Wheel-sensor emulator: drives the active-low fork line with one low pulse per
// simulated revolution at a programmable period, pulse width and revolution count.
module fork_sensor_gen #(
    parameter int PERIOD_W = 20,
    parameter int REV_W    = 16
) (
    input  logic                clock,
    input  logic                nRst,
    input  logic                load,
    input  logic [PERIOD_W-1:0] period_in,
    input  logic [PERIOD_W-1:0] width_in,
    input  logic [REV_W-1:0]    revs_in,
    input  logic                start,
    input  logic                stop,
    output logic                nFork,
    output logic [REV_W-1:0]    revs,
    output logic                busy,
    output logic                done,
    output logic                cfg_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [PERIOD_W-1:0] PERIOD_MIN = PERIOD_W'(2);
    localparam logic [PERIOD_W-1:0] CNT_ZERO   = {PERIOD_W{1'b0}};
    localparam logic [PERIOD_W-1:0] CNT_ONE    = PERIOD_W'(1);
    localparam logic [REV_W-1:0]    REV_ZERO   = {REV_W{1'b0}};
    localparam logic [REV_W-1:0]    REV_ONE    = REV_W'(1);

    // A configuration is usable only if it leaves a non-empty low and high phase.
    function automatic logic cfg_invalid(input logic [PERIOD_W-1:0] p,
                                         input logic [PERIOD_W-1:0] w);
        return (p < PERIOD_MIN) | (w == CNT_ZERO) | (w >= p);
    endfunction

    logic [1:0]          state_r;
    logic [PERIOD_W-1:0] cnt_r;
    logic [PERIOD_W-1:0] period_r;
    logic [PERIOD_W-1:0] width_r;
    logic [REV_W-1:0]    target_r;

    logic [1:0]          state_s;
    logic [PERIOD_W-1:0] cnt_s;
    logic [PERIOD_W-1:0] period_s;
    logic [PERIOD_W-1:0] width_s;
    logic [REV_W-1:0]    target_s;
    logic [REV_W-1:0]    revs_s;
    logic                cfg_err_s;
    logic                idle_or_done_s;
    logic [PERIOD_W-1:0] cnt_inc_s;
    logic [PERIOD_W-1:0] hi_len_s;
    logic [REV_W-1:0]    revs_inc_s;

    // Next-state logic; stop outranks load, which outranks start.
    always_comb begin
        state_s        = state_r;
        cnt_s          = cnt_r;
        period_s       = period_r;
        width_s        = width_r;
        target_s       = target_r;
        revs_s         = revs;
        cfg_err_s      = cfg_err;
        idle_or_done_s = (state_r == ST_IDLE) || (state_r == ST_DONE);
        cnt_inc_s      = cnt_r + CNT_ONE;
        hi_len_s       = period_r - width_r;
        revs_inc_s     = revs + REV_ONE;

        if (stop) begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
        end else if (load && idle_or_done_s) begin
            period_s  = period_in;
            width_s   = width_in;
            target_s  = revs_in;
            cfg_err_s = cfg_invalid(period_in, width_in);
            state_s   = ST_IDLE;
        end else if (start && idle_or_done_s && !cfg_err) begin
            revs_s  = REV_ZERO;
            cnt_s   = CNT_ZERO;
            state_s = ST_LOW;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_LOW: begin
                    if (cnt_inc_s == width_r) begin
                        state_s = ST_HIGH;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end
                ST_HIGH: begin
                    if (cnt_inc_s == hi_len_s) begin
                        revs_s = revs_inc_s;
                        cnt_s  = CNT_ZERO;
                        if ((target_r != REV_ZERO) && (revs_inc_s == target_r)) begin
                            state_s = ST_DONE;
                        end else begin
                            state_s = ST_LOW;
                        end
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end
                ST_DONE: begin
                    state_s = ST_DONE;
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // State, configuration and registered outputs derived from the next state.
    always_ff @(posedge clock) begin
        if (!nRst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            period_r <= CNT_ZERO;
            width_r  <= CNT_ZERO;
            target_r <= REV_ZERO;
            revs     <= REV_ZERO;
            cfg_err  <= 1'b1;
            nFork    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            period_r <= period_s;
            width_r  <= width_s;
            target_r <= target_s;
            revs     <= revs_s;
            cfg_err  <= cfg_err_s;
            nFork    <= (state_s != ST_LOW);
            busy     <= (state_s == ST_LOW) || (state_s == ST_HIGH);
            done     <= (state_s == ST_DONE);
        end
    end

endmodule
